// File: rtl/d5m_axis_packer.sv
// D5M parallel pixel bus to AXI4-Stream video: SOF on tuser, EOL on tlast, FWFT FIFO for backpressure.
// Define D5M_AXIS_STATS_EN to build the frame_count/line_count statistics counters.
module d5m_axis_packer #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  pixclk,
  input  logic                  reset,
  input  logic                  ifval,
  input  logic                  ilval,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  rgb_m_axis_tready,
  output logic                  rgb_m_axis_tvalid,
  output logic                  rgb_m_axis_tlast,
  output logic                  rgb_m_axis_tuser,
  output logic [DATA_WIDTH-1:0] rgb_m_axis_tdata,
  output logic                  overflow,
  output logic [15:0]           frame_count,
  output logic [11:0]           line_count
);

  localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned EntryW = DATA_WIDTH + 2;
  localparam logic [AddrW:0] FullCnt = (AddrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StSync, StWaitSof, StActive, StDrop} state_e;

  state_e                  state_q;
  logic                    fval_q;
  logic                    sof_arm_q;
  logic                    hold_valid_q;
  logic                    hold_sof_q;
  logic [DATA_WIDTH-1:0]   hold_data_q;
  logic [EntryW-1:0]       mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]        wr_ptr_q;
  logic [AddrW-1:0]        rd_ptr_q;
  logic [AddrW:0]          count_q;
  logic                    overflow_q;

  logic                    pix;
  logic                    frame_fall;
  logic                    fifo_full;
  logic                    pop;
  logic                    push_req;
  logic                    push_ok;
  logic                    push_fail;
  logic                    wr_eol;
  logic [EntryW-1:0]       head;

  always_comb begin
    pix        = ifval && ilval;
    frame_fall = fval_q && !ifval;
    fifo_full  = (count_q == FullCnt);
    pop        = (count_q != '0) && rgb_m_axis_tready;
    // The held pixel is the last of its line unless another pixel follows immediately.
    wr_eol     = !pix;
    push_req   = (state_q == StActive) && hold_valid_q;
    push_ok    = push_req && (!fifo_full || pop);
    push_fail  = push_req && !push_ok;
    head       = mem_q[rd_ptr_q];
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      state_q      <= StSync;
      fval_q       <= 1'b0;
      sof_arm_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_sof_q   <= 1'b0;
      hold_data_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      fval_q <= ifval;

      if (push_ok) begin
        mem_q[wr_ptr_q] <= {hold_sof_q, wr_eol, hold_data_q};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;

      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase

      if (push_fail) overflow_q <= 1'b1;

      unique case (state_q)
        StSync: begin
          if (!ifval) state_q <= StWaitSof;
        end
        StWaitSof: begin
          if (ifval && !fval_q) begin
            state_q   <= StActive;
            sof_arm_q <= 1'b1;
          end
        end
        StActive: begin
          if (push_fail) begin
            // A lost pixel ruins the rest of the frame; discard the hold too.
            hold_valid_q <= 1'b0;
            state_q      <= frame_fall ? StWaitSof : StDrop;
          end else if (frame_fall) begin
            hold_valid_q <= 1'b0;
            state_q      <= StWaitSof;
          end else if (pix) begin
            hold_valid_q <= 1'b1;
            hold_data_q  <= idata;
            hold_sof_q   <= sof_arm_q;
            sof_arm_q    <= 1'b0;
          end else begin
            hold_valid_q <= 1'b0;
          end
        end
        StDrop: begin
          if (frame_fall) state_q <= StWaitSof;
        end
        default: state_q <= StSync;
      endcase
    end
  end

  assign rgb_m_axis_tvalid = (count_q != '0);
  assign rgb_m_axis_tuser  = rgb_m_axis_tvalid ? head[EntryW-1] : 1'b0;
  assign rgb_m_axis_tlast  = rgb_m_axis_tvalid ? head[EntryW-2] : 1'b0;
  assign rgb_m_axis_tdata  = rgb_m_axis_tvalid ? head[DATA_WIDTH-1:0] : '0;
  assign overflow          = overflow_q;

`ifdef D5M_AXIS_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [11:0] line_cnt_q;

  always_ff @(posedge pixclk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      line_cnt_q  <= '0;
    end else begin
      if (push_ok) begin
        if (hold_sof_q) line_cnt_q <= {11'd0, wr_eol};
        else if (wr_eol) line_cnt_q <= line_cnt_q + 12'd1;
      end
      if ((state_q == StActive) && frame_fall) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_count = frame_cnt_q;
  assign line_count  = line_cnt_q;
`else
  assign frame_count = '0;
  assign line_count  = '0;
`endif

endmodule

// File: tb/tb_d5m_axis_packer.sv
// Scoreboard bench for d5m_axis_packer: frames are described at line/pixel level and the
// expected beats {tuser, tlast, data} queued as they are driven; a monitor pops and compares.
module tb_d5m_axis_packer;

  localparam int DW    = 24;
  localparam int DEPTH = 16;

  logic          pixclk = 1'b0;
  logic          reset;
  logic          ifval;
  logic          ilval;
  logic [DW-1:0] idata;
  logic          tready;
  logic          tvalid;
  logic          tlast;
  logic          tuser;
  logic [DW-1:0] tdata;
  logic          overflow;
  logic [15:0]   frame_count;
  logic [11:0]   line_count;

  always #5 pixclk = ~pixclk;

  d5m_axis_packer #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .pixclk            (pixclk),
    .reset             (reset),
    .ifval             (ifval),
    .ilval             (ilval),
    .idata             (idata),
    .rgb_m_axis_tready (tready),
    .rgb_m_axis_tvalid (tvalid),
    .rgb_m_axis_tlast  (tlast),
    .rgb_m_axis_tuser  (tuser),
    .rgb_m_axis_tdata  (tdata),
    .overflow          (overflow),
    .frame_count       (frame_count),
    .line_count        (line_count)
  );

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            tr_mode = 0;
  int            last_rise = -1;
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] exp_beat;
  logic          prev_stall = 1'b0;
  logic          prev_tv = 1'b0;
  logic [DW+1:0] prev_beat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge pixclk);
    #1;
  endtask

  always @(posedge pixclk) cyc <= cyc + 1;

  // Backpressure pattern, changed just after each edge.
  initial begin
    tready = 1'b1;
    forever begin
      step();
      case (tr_mode)
        0:       tready = 1'b1;
        1:       tready = (cyc % 3 == 0);
        2:       tready = 1'b0;
        default: tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard compare on each accepted beat, plus stall stability.
  always @(negedge pixclk) begin
    if (reset) begin
      prev_stall <= 1'b0;
      prev_tv    <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(tvalid), 32'd1);
        check("stall_payload", 32'({tuser, tlast, tdata}), 32'(prev_beat));
      end
      if (tvalid && !prev_tv) last_rise <= cyc;
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h expected no beat (cycle %0d)",
                   {tuser, tlast, tdata}, cyc);
        end else begin
          exp_beat = exp_q.pop_front();
          check("beat", 32'({tuser, tlast, tdata}), 32'(exp_beat));
        end
      end
      prev_stall <= tvalid && !tready;
      prev_tv    <= tvalid;
      prev_beat  <= {tuser, tlast, tdata};
    end
  end

  task automatic drive_frame(input int nlines, input int npix, input int gap,
                             input bit pattern, input bit push_exp, input bit chk_lat);
    logic [DW-1:0] d;
    int t0;
    t0 = 0;
    step(); ifval = 1'b1; ilval = 1'b0;
    step();
    step();
    for (int l = 0; l < nlines; l++) begin
      for (int c = 0; c < npix; c++) begin
        step();
        d = pattern ? DW'(l * 16 + c) : DW'($urandom);
        ilval = 1'b1;
        idata = d;
        if (l == 0 && c == 0) t0 = cyc;
        if (push_exp) exp_q.push_back({(l == 0 && c == 0), (c == npix - 1), d});
      end
      for (int g = 0; g < gap; g++) begin
        step();
        ilval = 1'b0;
      end
      if (chk_lat && l == 0) check("first_valid_latency", 32'(last_rise - t0), 32'd2);
    end
    step(); ifval = 1'b0; ilval = 1'b0;
    repeat (4) step();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) step();
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
    repeat (3) step();
  endtask

  task automatic check_stats(input int frames, input int lines);
`ifdef D5M_AXIS_STATS_EN
    check("frame_count", 32'(frame_count), 32'(frames));
    check("line_count", 32'(line_count), 32'(lines));
`else
    check("frame_count", 32'(frame_count), 32'(frames * 0));
    check("line_count", 32'(line_count), 32'(lines * 0));
`endif
  endtask

  initial begin
    logic [DW-1:0] d;
    reset = 1'b1; ifval = 1'b0; ilval = 1'b0; idata = '0;
    repeat (3) step();
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_tuser", 32'(tuser), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_line_count", 32'(line_count), 32'd0);
    reset = 1'b0;
    repeat (2) step();

    // 4x8 pattern frame, no backpressure.
    tr_mode = 0;
    drive_frame(4, 8, 6, 1'b1, 1'b1, 1'b1);
    wait_drain();

    // Reset released mid-frame: that frame must produce nothing.
    reset = 1'b1; ifval = 1'b1;
    repeat (2) step();
    check("rst_mid_tvalid", 32'(tvalid), 32'd0);
    reset = 1'b0;
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < 6; c++) begin
        step(); ilval = 1'b1; idata = DW'($urandom);
      end
      repeat (4) begin step(); ilval = 1'b0; end
    end
    step(); ifval = 1'b0;
    repeat (4) step();
    drive_frame(2, 5, 4, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // 1-of-3 backpressure with long line gaps.
    tr_mode = 1;
    drive_frame(4, 8, 24, 1'b1, 1'b1, 1'b0);
    wait_drain();
    check("overflow_after_throttle", 32'(overflow), 32'd0);

    // Frame ends while ilval is still high.
    tr_mode = 0;
    step(); ifval = 1'b1; ilval = 1'b0;
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      step(); d = DW'($urandom); ilval = 1'b1; idata = d;
      exp_q.push_back({(c == 0), (c == 4), d});
    end
    step(); ifval = 1'b0; ilval = 1'b1; idata = DW'($urandom);
    step(); ilval = 1'b0;
    repeat (4) step();
    drive_frame(2, 4, 3, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // Random backpressure, random frame shapes.
    tr_mode = 3;
    for (int f = 0; f < 4; f++)
      drive_frame($urandom_range(1, 3), $urandom_range(1, 8), 40, 1'b0, 1'b1, 1'b0);
    wait_drain();
    check("overflow_after_random", 32'(overflow), 32'd0);

    // Overflow: 40-pixel line with tready held low.
    tr_mode = 2;
    repeat (2) step();
    step(); ifval = 1'b1; ilval = 1'b0;
    step();
    step();
    for (int c = 0; c < 40; c++) begin
      step(); d = DW'($urandom); ilval = 1'b1; idata = d;
      if (c < DEPTH) exp_q.push_back({(c == 0), 1'b0, d});
    end
    step(); ilval = 1'b0;
    repeat (2) step();
    check("overflow_set", 32'(overflow), 32'd1);
    step(); ifval = 1'b0;
    repeat (2) step();
    tr_mode = 0;
    wait_drain();
    drive_frame(2, 6, 4, 1'b0, 1'b1, 1'b0);
    wait_drain();
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Statistics over three 4-line frames.
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (2) step();
    for (int f = 0; f < 3; f++) begin
      drive_frame(4, $urandom_range(2, 8), 4, 1'b0, 1'b1, 1'b0);
      wait_drain();
      check_stats(f + 1, 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
